// File: rtl/mkio_rt_dispatch.sv
// ---------------------------------------------------------------------------
// mkio_rt_dispatch
//   Remote-terminal command dispatcher. Decodes command words from the shared
//   decoder, starts one of four subaddress devices (sa 1..4), forwards the
//   selected device's response words to the shared encoder, and aborts a
//   device that stays busy too long.
//
//   Parameters
//     RT_ADDR  own remote-terminal address
//     TIMEOUT  maximum number of clk cycles spent in ACTIVE
//
//   Ports
//     clk, reset        clock, asynchronous active-high reset
//     rx_done/rx_data/rx_cd/p_error   decoded word strobe, word, type, parity
//     dev_start         one-hot start pulse, bit k = subaddress k+1
//     dev_busy          per-device busy
//     dev_tx_data/dev_tx_cd/dev_tx_ready   per-device response word request
//     tx_data/tx_cd/tx_ready           response word to the encoder
//     active_sa         subaddress being served, 0 when idle
//     err_timeout       one-cycle pulse when a transaction is aborted
//     ign_cnt           saturating count of rejected command words
//
//   Build option
//     MKIO_BROADCAST_EN  when defined, address 31 is accepted as broadcast:
//                        the device is started but no response is sent.
// ---------------------------------------------------------------------------

// Per-device slice: gates one device's request, word and busy by the
// current selection so the top level can simply OR the lanes together.
module mkio_rt_lane #(
    parameter logic [1:0] LANE = 2'd0
) (
    input  logic [1:0]  sel,
    input  logic        tx_req,
    input  logic        busy,
    input  logic [15:0] word,
    input  logic        cd,
    output logic        req_g,
    output logic        busy_g,
    output logic [15:0] word_g,
    output logic        cd_g
);
    logic hit;

    assign hit    = (sel == LANE);
    // Non-selected devices are masked here, so their requests never reach
    // the encoder path.
    assign req_g  = hit & tx_req;
    assign busy_g = hit & busy;
    assign word_g = hit ? word : 16'h0000;
    assign cd_g   = hit & cd;
endmodule

module mkio_rt_dispatch #(
    parameter logic [4:0]  RT_ADDR = 5'd1,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done,
    input  logic [15:0] rx_data,
    input  logic        rx_cd,
    input  logic        p_error,
    output logic [3:0]  dev_start,
    input  logic [3:0]  dev_busy,
    input  logic [63:0] dev_tx_data,
    input  logic [3:0]  dev_tx_cd,
    input  logic [3:0]  dev_tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_cd,
    output logic        tx_ready,
    output logic [4:0]  active_sa,
    output logic        err_timeout,
    output logic [7:0]  ign_cnt
);
    localparam int NUM_DEV = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_ACTIVE,
        ST_TIMEOUT
    } state_t;

    state_t      state;
    logic [1:0]  sel;
    logic [15:0] timer;
    logic        bcast_q;

    // ---------------- command decode ----------------
    logic [4:0] cmd_addr;
    logic [4:0] cmd_sa;
    logic [4:0] sa_m1;
    logic       cmd_valid;
    logic       cmd_bcast;
    logic       addr_ok;
    logic       sa_ok;
    logic       cmd_accept;
    logic       cmd_reject;
    logic [3:0] start_onehot;
    logic       unused_fields;

    assign cmd_addr = rx_data[15:11];
    assign cmd_sa   = rx_data[9:5];
    // T/R and word count are the device's business, not the dispatcher's.
    assign unused_fields = ^{rx_data[10], rx_data[4:0]};

    assign cmd_valid = rx_done & rx_cd;

`ifdef MKIO_BROADCAST_EN
    assign cmd_bcast = (cmd_addr == 5'd31);
`else
    assign cmd_bcast = 1'b0;
`endif

    assign addr_ok    = (cmd_addr == RT_ADDR) | cmd_bcast;
    assign sa_ok      = (cmd_sa >= 5'd1) & (cmd_sa <= 5'd4);
    assign cmd_accept = cmd_valid & addr_ok & sa_ok & ~p_error;
    assign cmd_reject = cmd_valid & ~cmd_accept;

    assign sa_m1        = cmd_sa - 5'd1;
    assign start_onehot = 4'b0001 << sa_m1[1:0];

    // ---------------- per-device lanes ----------------
    logic [NUM_DEV-1:0][15:0] dev_word;
    logic [NUM_DEV-1:0][15:0] lane_word;
    logic [NUM_DEV-1:0]       lane_req;
    logic [NUM_DEV-1:0]       lane_busy;
    logic [NUM_DEV-1:0]       lane_cd;

    assign dev_word = dev_tx_data;

    for (genvar k = 0; k < NUM_DEV; k++) begin : g_lane
        mkio_rt_lane #(.LANE(2'(k))) u_lane (
            .sel    (sel),
            .tx_req (dev_tx_ready[k]),
            .busy   (dev_busy[k]),
            .word   (dev_word[k]),
            .cd     (dev_tx_cd[k]),
            .req_g  (lane_req[k]),
            .busy_g (lane_busy[k]),
            .word_g (lane_word[k]),
            .cd_g   (lane_cd[k])
        );
    end

    logic        sel_req;
    logic        sel_busy;
    logic        sel_cd;
    logic [15:0] sel_word;

    assign sel_req  = |lane_req;
    assign sel_busy = |lane_busy;
    assign sel_cd   = |lane_cd;

    always_comb begin
        sel_word = 16'h0000;
        for (int k = 0; k < NUM_DEV; k++) begin
            sel_word = sel_word | lane_word[k];
        end
    end

    // ---------------- dispatcher FSM ----------------
    // All outputs are registered; the single-cycle pulses default low each
    // cycle and are raised on the transition that enters the state that
    // owns them, so dev_start is high exactly during DISPATCH and
    // err_timeout exactly during TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= 2'd0;
            timer       <= 16'h0000;
            bcast_q     <= 1'b0;
            dev_start   <= 4'b0000;
            tx_data     <= 16'h0000;
            tx_cd       <= 1'b0;
            tx_ready    <= 1'b0;
            active_sa   <= 5'd0;
            err_timeout <= 1'b0;
        end else begin
            dev_start   <= 4'b0000;
            tx_ready    <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        sel       <= sa_m1[1:0];
                        active_sa <= cmd_sa;
                        bcast_q   <= cmd_bcast;
                        dev_start <= start_onehot;
                        state     <= ST_DISPATCH;
                    end
                end

                ST_DISPATCH: begin
                    timer <= 16'h0000;
                    state <= ST_ACTIVE;
                end

                ST_ACTIVE: begin
                    timer <= timer + 16'd1;

                    // Response capture is independent of the state decision
                    // below, so a word requested in the last ACTIVE cycle
                    // still goes out. Broadcast transactions never answer.
                    if (sel_req && !bcast_q) begin
                        tx_data  <= sel_word;
                        tx_cd    <= sel_cd;
                        tx_ready <= 1'b1;
                    end

                    if (cmd_accept) begin
                        // Preemption: a new valid command replaces the
                        // current transaction without flagging an error.
                        sel       <= sa_m1[1:0];
                        active_sa <= cmd_sa;
                        bcast_q   <= cmd_bcast;
                        dev_start <= start_onehot;
                        state     <= ST_DISPATCH;
                    end else if (!sel_busy && timer >= 16'd1) begin
                        // The two-cycle floor gives the device time to raise
                        // busy after its start pulse.
                        active_sa <= 5'd0;
                        state     <= ST_IDLE;
                    end else if (timer == TIMEOUT - 16'd1) begin
                        active_sa   <= 5'd0;
                        err_timeout <= 1'b1;
                        state       <= ST_TIMEOUT;
                    end
                end

                ST_TIMEOUT: begin
                    // Device requests arriving here are not captured.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- rejected-command counter ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ign_cnt <= 8'd0;
        end else if (cmd_reject && ign_cnt != 8'hFF) begin
            ign_cnt <= ign_cnt + 8'd1;
        end
    end

endmodule
